// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the write-back stage.
// The decode and control blocks use the same result-source and load-type constants.
package writeback_unit_pkg;

    localparam int REG_ADDR_W = 5;

    // Result-source select (in_reg_src)
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC4 = 2'd2;
    localparam logic [1:0] SRC_IMM = 2'd3;

    // Load funct3 codes
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Selects the load target byte/halfword from an aligned memory word and extends it.
// Purely combinational; undefined load types fall back to a full-word load.
module load_align
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] value
);

    logic [7:0]  word_bytes [4];
    logic [15:0] word_halves [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_halves
            assign word_halves[gi] = word[16*gi +: 16];
        end
    endgenerate

    // Halfword loads ignore offset[0]; misalignment is the memory stage's concern.
    assign byte_sel = word_bytes[offset];
    assign half_sel = word_halves[offset[1]];

    always_comb begin
        value = word;
        case (load_type)
            LT_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            LT_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            LT_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            LT_LW:   value = word;
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: result selection, load completion, register-file write port,
// retired-instruction counter and sticky unexpected-response flag.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_reg_src,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_mem_read,
    input  logic [2:0]            in_load_type,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,
    output logic                  reg_write_enable,
    output logic [REG_ADDR_W-1:0] reg_write_addr,
    output logic [XLEN-1:0]       reg_write_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      instret,
    output logic                  rsp_err
);

    wb_state_t state_reg, state_next;

    // Pending-load context captured at acceptance
    logic [REG_ADDR_W-1:0] pend_rd_reg;
    logic                  pend_we_reg;
    logic [1:0]            pend_src_reg;
    logic [2:0]            pend_lt_reg;
    logic [1:0]            pend_off_reg;
    logic [XLEN-1:0]       pend_val_reg;

    logic                  we_reg;
    logic [REG_ADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]       data_reg;
    logic [CNT_W-1:0]      instret_reg;
    logic                  rsp_err_reg;

    logic                  accept;
    logic                  rsp_taken;
    logic                  commit_next;
    logic [XLEN-1:0]       in_value;
    logic [XLEN-1:0]       load_value;
    logic                  commit_we_next;
    logic [REG_ADDR_W-1:0] commit_addr_next;
    logic [XLEN-1:0]       commit_data_next;

    assign in_ready  = rst_n && (state_reg != ST_WAIT_MEM);
    assign busy      = (state_reg == ST_WAIT_MEM);
    assign accept    = in_valid && in_ready;
    assign rsp_taken = (state_reg == ST_WAIT_MEM) && mem_rsp_valid;

    // Non-memory result; a non-load tagged MEM has no data so it writes the ALU value.
    always_comb begin
        in_value = in_alu_result;
        case (in_reg_src)
            SRC_ALU: in_value = in_alu_result;
            SRC_PC4: in_value = in_pc + XLEN'(4);
            SRC_IMM: in_value = in_imm;
            default: in_value = in_alu_result;
        endcase
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .word      (mem_rsp_data),
        .offset    (pend_off_reg),
        .load_type (pend_lt_reg),
        .value     (load_value)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_COMMIT: begin
                if (accept) begin
                    state_next = in_mem_read ? ST_WAIT_MEM : ST_COMMIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_next = ST_COMMIT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Commit source: a completing load takes priority (no acceptance is possible in WAIT_MEM).
    always_comb begin
        commit_next      = rsp_taken || (accept && !in_mem_read);
        commit_we_next   = in_reg_write && (in_rd != '0);
        commit_addr_next = in_rd;
        commit_data_next = in_value;
        if (rsp_taken) begin
            commit_we_next   = pend_we_reg && (pend_rd_reg != '0);
            commit_addr_next = pend_rd_reg;
            commit_data_next = (pend_src_reg == SRC_MEM) ? load_value : pend_val_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pend_rd_reg  <= '0;
            pend_we_reg  <= 1'b0;
            pend_src_reg <= SRC_ALU;
            pend_lt_reg  <= LT_LW;
            pend_off_reg <= '0;
            pend_val_reg <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            instret_reg  <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (accept && in_mem_read) begin
                pend_rd_reg  <= in_rd;
                pend_we_reg  <= in_reg_write;
                pend_src_reg <= in_reg_src;
                pend_lt_reg  <= in_load_type;
                pend_off_reg <= in_alu_result[1:0];
                pend_val_reg <= in_value;
            end

            we_reg <= 1'b0;
            if (commit_next) begin
                we_reg      <= commit_we_next;
                addr_reg    <= commit_addr_next;
                data_reg    <= commit_data_next;
                instret_reg <= instret_reg + CNT_W'(1);
            end

            if (mem_rsp_valid && (state_reg != ST_WAIT_MEM)) begin
                rsp_err_reg <= 1'b1;
            end
        end
    end

    assign reg_write_enable = we_reg;
    assign reg_write_addr   = addr_reg;
    assign reg_write_data   = data_reg;
    assign instret          = instret_reg;
    assign rsp_err          = rsp_err_reg;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back end of the five-stage pipeline: it accepts completed instructions from the memory stage, and for loads it waits on the data-memory response and byte/half aligns and extends the data. It selects the result source and drives the register-file write port that the decode stage's register file samples. It also keeps a retired-instruction counter and flags protocol errors on the memory response path.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  unit accepts the instruction this cycle
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_reg_src  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
- in_alu_result  in  XLEN  ALU result; bits [1:0] are the load byte offset
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  immediate
- in_mem_read  in  1  instruction is a load
- in_load_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_rsp_valid  in  1  data-memory read data valid (single-cycle pulse)
- mem_rsp_data  in  XLEN  aligned 32-bit word containing the load target
- reg_write_enable  out  1  register-file write strobe
- reg_write_addr  out  5  register-file write address
- reg_write_data  out  XLEN  register-file write data
- busy  out  1  a load is outstanding
- instret  out  CNT_W  retired-instruction count
- rsp_err  out  1  sticky: a response arrived with no load outstanding

## Operation
- States: IDLE, WAIT_MEM, COMMIT.
- Acceptance is in_valid & in_ready. in_ready = 1 in IDLE and COMMIT and 0 in WAIT_MEM.
- Non-load accepted → COMMIT. The result is selected by in_reg_src: ALU = in_alu_result, PC+4 = in_pc + 4 modulo 2^32, IMM = in_imm.
- Load accepted (in_mem_read = 1) → WAIT_MEM, latching rd, reg_write, load_type and offset.
- In WAIT_MEM, mem_rsp_valid → COMMIT with the extended data.
- Extension: LB/LBU select byte offset[1:0] and sign/zero extend. LH/LHU select halfword offset[1]; offset[0] is ignored. LW uses the full word. Undefined load_type codes are treated as LW.
- A load carrying in_reg_src ≠ MEM still waits for its response, then commits the selected non-MEM value.
- COMMIT asserts reg_write_enable = reg_write & (rd ≠ 0) for exactly one cycle and increments instret by one, including when rd = 0. instret wraps from 2^CNT_W−1 to 0.
- COMMIT with no new acceptance → IDLE. COMMIT with an acceptance → COMMIT (non-load) or WAIT_MEM (load).
- mem_rsp_valid in IDLE or COMMIT sets rsp_err, and the data is discarded. rsp_err clears only on reset.
- busy = (state == WAIT_MEM).

## Timing
- All outputs are registered except in_ready and busy, which decode the state.
- Reset values: state IDLE, reg_write_enable 0, reg_write_addr 0, reg_write_data 0, instret 0, rsp_err 0. in_ready is 0 while rst_n = 0 and 1 in the first cycle after release.
- Non-load accepted in cycle T → write strobe in cycle T+1. Back-to-back non-loads sustain one commit per cycle.
- Load accepted in T with the response in T+k (k ≥ 1) → write strobe in T+k+1. The next instruction can be accepted in T+k+1.
- A response in the same cycle as the load's acceptance does not count for that load and sets rsp_err.
- rst_n low in any state, including WAIT_MEM, drops the pending load with no write and no count. A stale response after reset sets rsp_err; suppressing it is the environment's job.
- The register file samples the write on the clk edge that ends the strobe cycle. Same-cycle read bypass is handled in decode, not here.

## Structure
- Shared package holds the reg_src encodings, the load_type funct3 constants and the state enum. The decode and control blocks use the same constants.
- One combinational sub-module, load_align: inputs word, offset and load_type; output the extended value.
- The top level holds the FSM, result mux, output registers and counter.

## Test plan
- ADDI-style: rd=5, src ALU, alu_result 0x0000_1234 accepted at T → T+1 strobe, addr 5, data 0x0000_1234, instret 1.
- LB offset 3, response 0x80FF_0000 two cycles later → data 0xFFFF_FF80. LBU same → 0x0000_0080. LH offset 2 → 0xFFFF_80FF.
- JAL: src PC+4, pc 0xFFFF_FFFC → data 0x0000_0000. rd=0 → no strobe, instret still increments.
- In WAIT_MEM, in_valid held → in_ready 0 until the response. A response while IDLE → rsp_err = 1 and no write.
- Preset instret to 0xFFFF_FFFF via 2^32−1 commits (or use a small CNT_W such as 4) → next commit wraps it to 0.
- rst_n low during WAIT_MEM, then a late response → no write, instret 0, rsp_err 1.
